mp_add_seq: RTL and testbench
=============================

// Module: mp_add_seq
// PURPOSE
//  Multi-precision add sequencer: adds two NBYTES*8-bit operands one byte per
//  cycle through the existing external 8-bit combinational adder
//  (X, Y, C0 -> S, C8). Sits directly upstream of that adder: drives its
//  operands and carry-in, and captures its sum and carry-out. C8 is chained
//  back into C0 on the next byte.
// PARAMETERS
//  NBYTES  4  operand width in bytes; legal range 1..16
// PORTS
//  clk        in   1          clock; all state updates on the rising edge
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          request; sampled in IDLE or DONE only
//  a          in   8*NBYTES   operand A, captured on accepted start
//  b          in   8*NBYTES   operand B, captured on accepted start
//  cin        in   1          initial carry, captured on accepted start
//  sub        in   1          subtract request (used only under MPADD_SUB_EN)
//  busy       out  1          high while in ADD
//  done       out  1          one-cycle pulse; sum/cout/ovf valid from this cycle
//  sum        out  8*NBYTES   result; held until next accepted start or reset
//  cout       out  1          carry out of the top byte
//  ovf        out  1          signed overflow of the full-width add
//  add_x      out  8          to adder X, registered
//  add_y      out  8          to adder Y, registered
//  add_c0     out  1          to adder C0
//  add_s      in   8          from adder S; combinational from add_x/add_y/add_c0
//  add_c8     in   1          from adder C8
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - State -> IDLE.
//    - busy, done, sum, cout, ovf, add_x, add_y, add_c0, byte index, carry reg all 0.
//  - FSM states: IDLE, ADD, DONE.
//    - IDLE -> ADD on start.
//    - ADD -> DONE after byte NBYTES-1.
//    - DONE -> ADD on start, else -> IDLE.
//  - Accept (start=1 in IDLE or DONE, edge T):
//    - Latch a, b, cin.
//    - Index = 0; add_x = a[7:0], add_y = b[7:0].
//    - sum is cleared to 0.
//  - ADD cycle i (i = 0..NBYTES-1):
//    - Adder sees byte i; add_c0 = cin_reg when i = 0, else carry reg.
//    - At the edge: sum[8i+7:8i] <= add_s; carry reg <= add_c8.
//    - add_x/add_y advance to byte i+1.
//  - Last byte edge: cout <= add_c8; ovf <= (x7 == y7) && (s7 != x7), using top-byte bit 7.
//  - Latency:
//    - busy high in cycles T+1 .. T+NBYTES.
//    - done high in cycle T+NBYTES+1 only.
//  - start while busy: ignored, no effect on the operation in flight.
//  - start in the DONE cycle: accepted. done still pulses that cycle; busy rises
//    the next cycle. sum/cout/ovf clear at that edge.
//  - NBYTES = 1: single ADD cycle; add_c0 = cin.
//  - Reset mid-operation: immediate abort to the reset values; no done pulse.
//    The next start runs a clean operation.
//  - In IDLE/DONE: add_x/add_y hold their last values; add_c0 = 0.
// CONFIGURATION
//  MPADD_SUB_EN defined:
//   - On start with sub = 1: latch ~b and force initial carry = 1 (cin ignored).
//   - Result is sum = a - b mod 2^(8*NBYTES).
//   - cout = 1 means no borrow.
//   - ovf is signed subtraction overflow, computed from inverted-B top byte.
//   - sub = 0 behaves as the plain add.
//  MPADD_SUB_EN undefined:
//   - sub is ignored; the block always adds.
// TESTING (NBYTES=4, start pulsed 1 cycle at edge T)
//  1. rst_n=0 mid-run -> all outputs 0 immediately, busy 0, no done;
//     next op gives correct result.
//  2. a=0x000000FF, b=0x00000001, cin=0 -> done at T+5; sum=0x00000100,
//     cout=0, ovf=0; add_c0=1 in cycle T+2.
//  3. a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0.
//  4. a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0, ovf=1.
//  5. start re-pulsed at T+2 -> ignored, done still at T+5;
//     start at T+5 (DONE) -> accepted, second done at T+10.
//  6. MPADD_SUB_EN, a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0;
//     without the macro -> sum=0x0000000C.

Source files
------------

// File: rtl/mp_add_seq.sv
// ----------------------------------------------------------------------------
// mp_add_seq
//   Multi-precision add sequencer. Adds two NBYTES*8-bit operands one byte per
//   cycle through an external 8-bit combinational adder (X, Y, C0 -> S, C8).
//   The adder's carry-out is chained back into its carry-in on the next byte.
//
// Parameters
//   NBYTES   operand width in bytes (1..16)
//
// Optional feature
//   MPADD_SUB_EN  when defined, start with sub=1 computes a - b by latching
//                 ~b and forcing the initial carry to 1. When undefined, sub
//                 is ignored and the block always adds.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request; accepted in IDLE or DONE only
//   a, b, cin      operands and initial carry, captured on accept
//   sub            subtract request (MPADD_SUB_EN only)
//   busy           high while bytes are being added
//   done           one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum            result, held until the next accepted start or reset
//   cout           carry out of the top byte
//   ovf            signed overflow of the full-width operation
//   add_x, add_y   registered operand bytes to the external adder
//   add_c0         carry-in to the external adder
//   add_s, add_c8  sum byte and carry-out from the external adder
// ----------------------------------------------------------------------------
module mp_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf,
    output logic [7:0]          add_x,
    output logic [7:0]          add_y,
    output logic                add_c0,
    input  logic [7:0]          add_s,
    input  logic                add_c8
);

    localparam int unsigned W        = 8 * NBYTES;
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic [7:0]       r_add_x;
    logic [7:0]       r_add_y;
    // Doubles as the inter-byte carry register while in ADD; 0 otherwise.
    logic             r_add_c0;

    logic [W-1:0]     w_b_in;
    logic             w_c_in;
    logic             w_accept;
    logic [IDX_W-1:0] w_nidx;
    logic             w_ovf;

    // Operand B and initial carry as captured on accept.
`ifdef MPADD_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_in       = b;
    assign w_c_in       = cin;
`endif

    assign w_accept = start && (r_state != S_ADD);
    assign w_nidx   = r_idx + IDX_W'(1);

    // Signed overflow from the top byte currently on the adder.
    assign w_ovf = (r_add_x[7] == r_add_y[7]) && (add_s[7] != r_add_x[7]);

    // Sequencer: state, byte index, operand registers and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_add_x  <= '0;
            r_add_y  <= '0;
            r_add_c0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_add_c0 <= 1'b0;
                    if (w_accept) begin
                        r_state  <= S_ADD;
                        r_a      <= a;
                        r_b      <= w_b_in;
                        r_idx    <= '0;
                        r_add_x  <= a[7:0];
                        r_add_y  <= w_b_in[7:0];
                        r_add_c0 <= w_c_in;
                        r_sum    <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_sum[8*r_idx +: 8] <= add_s;
                    if (r_idx == LAST_IDX) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_cout   <= add_c8;
                        r_ovf    <= w_ovf;
                        r_add_c0 <= 1'b0;
                    end else begin
                        r_idx    <= w_nidx;
                        r_add_x  <= r_a[8*w_nidx +: 8];
                        r_add_y  <= r_b[8*w_nidx +: 8];
                        r_add_c0 <= add_c8;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_add_c0 <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign add_x  = r_add_x;
    assign add_y  = r_add_y;
    assign add_c0 = r_add_c0;

endmodule

// File: tb/tb_mp_add_seq.sv
// ----------------------------------------------------------------------------
// tb_mp_add_seq
//   Self-checking bench for mp_add_seq (NBYTES=4). Models the external 8-bit
//   adder, and predicts sum/cout/ovf and per-byte carry-in with plain
//   full-width arithmetic.
// ----------------------------------------------------------------------------
module tb_mp_add_seq;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [7:0]   add_x;
    logic [7:0]   add_y;
    logic         add_c0;
    logic [7:0]   add_s;
    logic         add_c8;

    int n_checks = 0;
    int n_pass   = 0;

    mp_add_seq #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .add_x  (add_x),
        .add_y  (add_y),
        .add_c0 (add_c0),
        .add_s  (add_s),
        .add_c8 (add_c8)
    );

    // External 8-bit combinational adder.
    assign {add_c8, add_s} = 9'(add_x) + 9'(add_y) + 9'(add_c0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: effective operands, result, carry into byte k.
    function automatic logic [63:0] eff_b(input logic [W-1:0] bv, input logic s);
`ifdef MPADD_SUB_EN
        return s ? 64'(~bv) : 64'(bv);
`else
        return 64'(bv);
`endif
    endfunction

    function automatic logic eff_c(input logic c, input logic s);
`ifdef MPADD_SUB_EN
        return s ? 1'b1 : c;
`else
        return c;
`endif
    endfunction

    function automatic logic [63:0] model_full(input logic [W-1:0] av, input logic [W-1:0] bv,
                                               input logic c, input logic s);
        return 64'(av) + eff_b(bv, s) + 64'(eff_c(c, s));
    endfunction

    function automatic logic model_carry_in(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic c, input logic s, input int k);
        logic [63:0] mask;
        logic [63:0] part;
        if (k == 0) return eff_c(c, s);
        mask = (64'd1 << (8 * k)) - 64'd1;
        part = (64'(av) & mask) + (eff_b(bv, s) & mask) + 64'(eff_c(c, s));
        return part[8*k];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic c, input logic s);
        logic [63:0] full;
        logic [63:0] be;
        full = model_full(av, bv, c, s);
        be   = eff_b(bv, s);
        return (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
    endfunction

    // One complete operation from accept to done, checked every cycle.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic c, input logic s);
        logic [63:0] full;
        full  = model_full(av, bv, c, s);
        a     = av;
        b     = bv;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom());
        b     = W'($urandom());
        for (int k = 0; k < int'(NBYTES); k++) begin
            check({tag, "_busy"}, 64'(busy), 64'(1));
            check({tag, "_done_early"}, 64'(done), 64'(0));
            check({tag, "_c0"}, 64'(add_c0), 64'(model_carry_in(av, bv, c, s, k)));
            tick();
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_busy_end"}, 64'(busy), 64'(0));
        check({tag, "_sum"}, 64'(sum), 64'(full[W-1:0]));
        check({tag, "_cout"}, 64'(cout), 64'(full[W]));
        check({tag, "_ovf"}, 64'(ovf), 64'(model_ovf(av, bv, c, s)));
        check({tag, "_c0_idle"}, 64'(add_c0), 64'(0));
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [63:0] exp1;
        logic [63:0] exp2;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout_ovf", 64'({cout, ovf}), 64'(0));
        check("rst_adder", 64'({add_x, add_y, add_c0}), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Carry ripple across byte 0 -> byte 1.
        run_op("t2", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        check("t2_sum_const", 64'(sum), 64'h0000_0100);
        check("t2_cout_ovf", 64'({cout, ovf}), 64'(0));

        // Full-width wrap.
        run_op("t3", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("t3_sum_const", 64'(sum), 64'h0);
        check("t3_cout_const", 64'(cout), 64'(1));

        // Signed overflow via carry-in.
        run_op("t4", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        check("t4_sum_const", 64'(sum), 64'h8000_0000);
        check("t4_ovf_const", 64'({cout, ovf}), 64'(1));

        // Subtract request.
        run_op("t6", 32'd5, 32'd7, 1'b0, 1'b1);
`ifdef MPADD_SUB_EN
        check("t6_sum_const", 64'(sum), 64'hFFFF_FFFE);
        check("t6_cout_const", 64'(cout), 64'(0));
`else
        check("t6_sum_const", 64'(sum), 64'h0000_000C);
        check("t6_cout_const", 64'(cout), 64'(0));
`endif

        // Start while busy ignored; start in DONE accepted.
        exp1  = model_full(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        exp2  = model_full(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0);
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        tick();                       // T+1
        start = 1'b0;
        tick();                       // T+2
        a     = 32'hDEAD_BEEF;
        b     = 32'hCAFE_F00D;
        cin   = 1'b1;
        start = 1'b1;
        tick();                       // T+3
        start = 1'b0;
        check("t5_busy_t3", 64'(busy), 64'(1));
        tick();                       // T+4
        tick();                       // T+5
        check("t5_done1", 64'(done), 64'(1));
        check("t5_sum1", 64'(sum), 64'(exp1[W-1:0]));
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5B;
        cin   = 1'b0;
        start = 1'b1;
        tick();                       // T+6
        start = 1'b0;
        check("t5_busy_t6", 64'(busy), 64'(1));
        check("t5_done_t6", 64'(done), 64'(0));
        check("t5_sum_clr", 64'(sum), 64'(0));
        for (int k = 0; k < 3; k++) tick();
        check("t5_no_done_t9", 64'(done), 64'(0));
        tick();                       // T+10
        check("t5_done2", 64'(done), 64'(1));
        check("t5_sum2", 64'(sum), 64'(exp2[W-1:0]));
        check("t5_cout2", 64'(cout), 64'(exp2[W]));
        tick();

        // Reset mid-operation aborts without a done pulse.
        a     = 32'h0F0F_0F0F;
        b     = 32'hF0F0_F0F1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t1_busy", 64'(busy), 64'(0));
        check("t1_sum", 64'(sum), 64'(0));
        check("t1_flags", 64'({done, cout, ovf}), 64'(0));
        check("t1_adder", 64'({add_x, add_y, add_c0}), 64'(0));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("t1_no_done", 64'({done, busy}), 64'(0));
            tick();
        end
        run_op("t1_next", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 20; n++) begin
            run_op("rnd", W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
